// File: rtl/fifo_rr_ctrl.sv
// Round-robin write arbiter and read sequencer in front of an external FIFO.
// Occupancy is tracked at issue time so gating never waits on the FIFO's own flags.
module fifo_rr_ctrl #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    input  logic               pop_req,
    output logic               pop_valid,
    output logic [DW-1:0]      pop_data,
    input  logic               flush,
    output logic [2:0]         level,
    output logic               busy,
    output logic               fifo_rst,
    output logic               fifo_wr_en,
    output logic [DW-1:0]      fifo_datain,
    output logic               fifo_rd_en,
    input  logic [DW-1:0]      fifo_dataout,
    input  logic               fifo_full,
    input  logic               fifo_empty
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0] DEPTH_L = 3'(DEPTH);

    typedef enum logic [1:0] {HOLD, RUN, FLUSH} state_e;

    state_e          state_q, state_d;
    logic            hold_cnt_q, hold_cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            wr_en_q, wr_en_d;
    logic [DW-1:0]   datain_q, datain_d;
    logic            rd_en_q, rd_en_d;
    logic            pop_valid_q, pop_valid_d;
    logic [2:0]      level_q, level_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            rd_first_q, rd_first_d;

    logic [NREQ-1:0] elig;
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic            w_ok, r_ok, do_w, do_r;

    // A requester still sees its own grant this cycle, so it sits out one round.
    always_comb begin
        elig      = req & ~gnt_q;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            logic [PW-1:0] idx;
            idx = PW'((int'(ptr_q) + k) % NREQ);
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = '0;
        wr_en_d     = 1'b0;
        datain_d    = '0;
        rd_en_d     = 1'b0;
        level_d     = level_q;
        ptr_d       = ptr_q;
        rd_first_d  = rd_first_q;
        do_w        = 1'b0;
        do_r        = 1'b0;
        w_ok        = win_found && (level_q < DEPTH_L);
        r_ok        = pop_req && (level_q != 3'd0);
        // A read already on the FIFO bus when flush arrives must not surface.
        pop_valid_d = rd_en_q & ~flush;

        case (state_q)
            HOLD: begin
                if (hold_cnt_q) state_d = RUN;
                else            hold_cnt_d = 1'b1;
            end
            FLUSH: state_d = RUN;
            default: begin
                if (flush) begin
                    state_d = FLUSH;
                    level_d = 3'd0;
                end else begin
                    if (w_ok && r_ok) begin
                        do_r       = rd_first_q;
                        do_w       = ~rd_first_q;
                        rd_first_d = ~rd_first_q;
                    end else begin
                        do_w = w_ok;
                        do_r = r_ok;
                    end
                    if (do_w) begin
                        gnt_d[win_idx] = 1'b1;
                        wr_en_d        = 1'b1;
                        datain_d       = wdata[win_idx*DW +: DW];
                        ptr_d          = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                        level_d        = level_q + 3'd1;
                    end
                    if (do_r) begin
                        rd_en_d = 1'b1;
                        level_d = level_q - 3'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HOLD;
            hold_cnt_q  <= 1'b0;
            gnt_q       <= '0;
            wr_en_q     <= 1'b0;
            datain_q    <= '0;
            rd_en_q     <= 1'b0;
            pop_valid_q <= 1'b0;
            level_q     <= 3'd0;
            ptr_q       <= '0;
            rd_first_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            wr_en_q     <= wr_en_d;
            datain_q    <= datain_d;
            rd_en_q     <= rd_en_d;
            pop_valid_q <= pop_valid_d;
            level_q     <= level_d;
            ptr_q       <= ptr_d;
            rd_first_q  <= rd_first_d;
        end
    end

    assign gnt         = gnt_q;
    assign fifo_wr_en  = wr_en_q;
    assign fifo_datain = datain_q;
    assign fifo_rd_en  = rd_en_q;
    assign pop_valid   = pop_valid_q;
    assign pop_data    = pop_valid_q ? fifo_dataout : '0;
    assign level       = level_q;
    assign busy        = (state_q != RUN);
    assign fifo_rst    = (state_q != RUN);

    // FIFO flags are only sanity-checked; the controller gates on level.
    a_flags_sane: assert property (@(posedge clk) disable iff (!rst_n) !(fifo_full && fifo_empty));
    a_wr_rd_excl: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en_q && rd_en_q));

endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// Scoreboard bench for fifo_rr_ctrl: a queue-based reference predicts grants, level
// and read data; a negedge monitor compares every cycle against a behavioural FIFO.
module tb_fifo_rr_ctrl;
    localparam int NREQ = 4, DW = 8, DEPTH = 4;

    logic clk, rst_n;
    logic [NREQ-1:0] req, gnt;
    logic [NREQ*DW-1:0] wdata;
    logic pop_req, pop_valid, flush, busy, fifo_rst, fifo_wr_en, fifo_rd_en;
    logic fifo_full, fifo_empty;
    logic [DW-1:0] pop_data, fifo_datain, fifo_dataout;
    logic [2:0] level;

    fifo_rr_ctrl #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .gnt(gnt),
        .pop_req(pop_req), .pop_valid(pop_valid), .pop_data(pop_data),
        .flush(flush), .level(level), .busy(busy), .fifo_rst(fifo_rst),
        .fifo_wr_en(fifo_wr_en), .fifo_datain(fifo_datain), .fifo_rd_en(fifo_rd_en),
        .fifo_dataout(fifo_dataout), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
    );

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural FIFO sitting behind the controller (registered read data).
    logic [DW-1:0] env_q[$];
    initial begin
        fifo_dataout = '0;
        fifo_full    = 1'b0;
        fifo_empty   = 1'b1;
        forever begin
            @(posedge clk);
            if (fifo_rst) env_q.delete();
            else begin
                if (fifo_wr_en && env_q.size() < DEPTH) env_q.push_back(fifo_datain);
                if (fifo_rd_en && env_q.size() > 0) fifo_dataout <= env_q.pop_front();
            end
            fifo_full  <= (env_q.size() == DEPTH);
            fifo_empty <= (env_q.size() == 0);
        end
    end

    // Reference model: state 0=HOLD 1=RUN 2=FLUSH; m_last is the previous winner.
    typedef struct { logic [DW-1:0] data; int due; } pop_t;
    pop_t pop_exp[$];
    logic [DW-1:0] content[$];
    int cyc, m_state, m_hcnt, m_cnt, m_last;
    bit m_rdfirst;
    logic [NREQ-1:0] exp_gnt;
    bit exp_wr, exp_rd;
    logic [DW-1:0] exp_data;

    initial begin : model
        logic [NREQ-1:0] elig;
        int win;
        bit w_ok, r_ok, do_w, do_r;
        pop_t p;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cyc = 0; m_state = 0; m_hcnt = 0; m_cnt = 0; m_last = NREQ - 1; m_rdfirst = 1;
                content.delete(); pop_exp.delete();
                exp_gnt = '0; exp_wr = 0; exp_rd = 0; exp_data = '0;
            end else begin
                cyc++;
                elig = req & ~exp_gnt;
                exp_gnt = '0; exp_wr = 0; exp_rd = 0; exp_data = '0;
                if (m_state == 0) begin
                    m_hcnt++;
                    if (m_hcnt >= 2) m_state = 1;
                end else if (m_state == 2) begin
                    m_state = 1;
                end else if (flush) begin
                    m_state = 2; m_cnt = 0; content.delete();
                    while (pop_exp.size() > 0 && pop_exp[$].due >= cyc) void'(pop_exp.pop_back());
                end else begin
                    win = -1;
                    for (int k = 1; k <= NREQ; k++) begin
                        int i;
                        i = (m_last + k) % NREQ;
                        if (win < 0 && elig[i]) win = i;
                    end
                    w_ok = (win >= 0) && (m_cnt < DEPTH);
                    r_ok = pop_req && (m_cnt > 0);
                    if (w_ok && r_ok) begin
                        do_r = m_rdfirst; do_w = !m_rdfirst; m_rdfirst = !m_rdfirst;
                    end else begin
                        do_w = w_ok; do_r = r_ok;
                    end
                    if (do_w) begin
                        exp_gnt[win] = 1'b1; exp_wr = 1;
                        exp_data = wdata[win*DW +: DW];
                        content.push_back(exp_data);
                        m_last = win; m_cnt++;
                    end
                    if (do_r) begin
                        p.data = content.pop_front(); p.due = cyc + 1;
                        pop_exp.push_back(p);
                        exp_rd = 1; m_cnt--;
                    end
                end
            end
        end
    end

    // Monitor: compares every cycle, pops the scoreboard whenever pop_valid shows.
    initial begin
        forever begin
            @(negedge clk);
            check("gnt", gnt, exp_gnt);
            check("fifo_wr_en", fifo_wr_en, exp_wr);
            check("fifo_datain", fifo_datain, exp_data);
            check("fifo_rd_en", fifo_rd_en, exp_rd);
            check("level", level, m_cnt);
            check("busy", busy, m_state != 1);
            check("fifo_rst", fifo_rst, m_state != 1);
            check("wr_rd_excl", fifo_wr_en & fifo_rd_en, 0);
            if (pop_valid) begin
                if (pop_exp.size() == 0 || pop_exp[0].due != cyc) check("pop_valid_spurious", pop_valid, 0);
                else begin
                    check("pop_data", pop_data, pop_exp[0].data);
                    void'(pop_exp.pop_front());
                end
            end else begin
                check("pop_data_idle", pop_data, 0);
                if (pop_exp.size() > 0 && pop_exp[0].due == cyc) begin
                    check("pop_valid_missing", pop_valid, 1);
                    void'(pop_exp.pop_front());
                end
            end
        end
    end

    task automatic randomize_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !gnt[i]) continue;
            if ($urandom_range(0, 99) < 50) begin
                req[i] = 1'b1;
                wdata[i*DW +: DW] = DW'($urandom);
            end else req[i] = 1'b0;
        end
        pop_req = ($urandom_range(0, 99) < 45);
        flush   = ($urandom_range(0, 99) < 3);
    endtask

    task automatic write_one(input logic [DW-1:0] v);
        req[1] = 1'b1; wdata[15:8] = v;
        step;
        req[1] = 1'b0;
        step;
    endtask

    initial begin
        int guard;
        rst_n = 1'b1; req = '0; wdata = '0; pop_req = 1'b0; flush = 1'b0;
        #1 rst_n = 1'b0;
        #3;
        check("rst_gnt", gnt, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 1);
        check("rst_fifo_rst", fifo_rst, 1);
        check("rst_pop_valid", pop_valid, 0);
        req = 4'hf; wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        #18 rst_n = 1'b1;

        // Two HOLD cycles, then all four requesters held.
        step; check("hold1_busy", busy, 1); check("hold1_fifo_rst", fifo_rst, 1); check("hold1_gnt", gnt, 0);
        step; check("run_busy", busy, 0); check("run_fifo_rst", fifo_rst, 0); check("early_gnt", gnt, 0);
        for (int k = 0; k < 4; k++) begin
            step; check("rr_gnt", gnt, 32'(1 << k)); check("rr_level", level, k + 1);
        end
        for (int k = 0; k < 3; k++) begin
            step; check("full_nognt", gnt, 0); check("full_level", level, 4);
        end

        req = '0; pop_req = 1'b1;
        repeat (4) step;
        pop_req = 1'b0;
        repeat (3) step;
        check("drain_level", level, 0);

        // Single requester held continuously: grant every other cycle.
        req = 4'b0100; wdata[23:16] = 8'h5a;
        for (int k = 0; k < 10; k++) begin
            step; check("solo_gnt2", gnt[2], (k % 2 == 0) && (k < 8));
        end
        req = '0;

        pop_req = 1'b1; repeat (2) step;
        pop_req = 1'b0; step;
        check("pre_conflict_level", level, 2);
        req = 4'b0001; pop_req = 1'b1;
        step; check("conf_rd_first", fifo_rd_en, 1); check("conf_rd_first_wr", fifo_wr_en, 0);
        step; check("conf_wr_second", fifo_wr_en, 1); check("conf_wr_second_rd", fifo_rd_en, 0);
        repeat (4) begin
            step; check("conf_excl", fifo_wr_en & fifo_rd_en, 0);
        end
        req = '0;

        guard = 0;
        while (level != 0 && guard < 10) begin step; guard++; end
        check("drain2_level", level, 0);
        pop_req = 1'b0; step; step;

        // Ordered data through the FIFO.
        write_one(8'h11); write_one(8'h22); write_one(8'h33);
        check("ordered_level", level, 3);
        pop_req = 1'b1; repeat (3) step;
        pop_req = 1'b0; step; step;
        check("ordered_drained", level, 0);

        // Flush with a read on the bus.
        write_one(8'ha1); write_one(8'hb2); write_one(8'hc3);
        check("fl_pre_level", level, 3);
        pop_req = 1'b1; step;
        pop_req = 1'b0; flush = 1'b1;
        check("fl_rd_inflight", fifo_rd_en, 1);
        step;
        check("fl_busy", busy, 1); check("fl_fifo_rst", fifo_rst, 1);
        check("fl_level", level, 0); check("fl_pop_suppressed", pop_valid, 0);
        flush = 1'b0;
        step; check("fl_resume", busy, 0); check("fl_pop_still_low", pop_valid, 0);

        repeat (500) begin randomize_inputs(); step; end

        // Reset while grants and reads are in flight.
        req = 4'hf; pop_req = 1'b1; flush = 1'b0;
        step; step;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", gnt, 0); check("mid_rst_wr", fifo_wr_en, 0);
        check("mid_rst_rd", fifo_rd_en, 0); check("mid_rst_pop", pop_valid, 0);
        check("mid_rst_datain", fifo_datain, 0); check("mid_rst_pop_data", pop_data, 0);
        check("mid_rst_level", level, 0); check("mid_rst_busy", busy, 1);
        check("mid_rst_fifo_rst", fifo_rst, 1);
        #13 rst_n = 1'b1;

        repeat (300) begin randomize_inputs(); step; end
        req = '0; pop_req = 1'b0; flush = 1'b0;
        repeat (5) step;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_rr_ctrl.md
FIFO_RR_CTRL -- requirements
Module: fifo_rr_ctrl

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have parameter DEPTH, default 4, controlled FIFO capacity in entries.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: req  in  NREQ  per-requester write request, held until granted; wdata  in  NREQ*DW  requester i data at bits [i*DW +: DW].
REQ-006 SHALL have ports: gnt  out  NREQ  one-hot one-cycle grant pulse; pop_req  in  1  consumer read request; pop_valid  out  1  pop_data valid strobe; pop_data  out  DW  read data.
REQ-007 SHALL have ports: flush  in  1  discard FIFO contents; level  out  3  committed occupancy 0..DEPTH; busy  out  1  high while not in RUN.
REQ-008 SHALL have FIFO-side ports: fifo_rst  out  1  active-high synchronous FIFO reset; fifo_wr_en  out  1; fifo_datain  out  DW; fifo_rd_en  out  1; fifo_dataout  in  DW; fifo_full  in  1; fifo_empty  in  1.

Function
REQ-009 SHALL implement FSM states HOLD, RUN, FLUSH; HOLD entered on reset, fifo_rst=1 in HOLD and FLUSH, busy=1 outside RUN.
REQ-010 SHALL stay in HOLD for exactly 2 cycles after rst_n deasserts, then enter RUN.
REQ-011 SHALL, in RUN with flush=1, enter FLUSH next cycle, remain 1 cycle, set level to 0, then return to RUN.
REQ-012 SHALL issue no grant, write or read in HOLD, FLUSH, or any cycle flush=1 is sampled.
REQ-013 SHALL arbitrate writes round-robin: search starts at index after last winner (index 0 after reset), lowest index wins ties from that start.
REQ-014 SHALL exclude from arbitration any requester whose gnt is high in the current cycle.
REQ-015 SHALL grant write in cycle t only if level < DEPTH after accounting for a read issued in t; eligible write at t -> gnt[i], fifo_wr_en=1, fifo_datain=wdata[i] all registered, high for exactly cycle t+1.
REQ-016 SHALL issue a read in cycle t when pop_req=1 and level > 0 -> fifo_rd_en=1 in cycle t+1, pop_valid=1 in cycle t+2 with pop_data=fifo_dataout in that cycle.
REQ-017 SHALL never assert fifo_wr_en and fifo_rd_en in the same cycle.
REQ-018 SHALL, when a write and a read are both eligible in one cycle, serve the side indicated by a priority toggle (reset: read first) and flip the toggle after each such conflict.
REQ-019 SHALL update level at issue time: +1 on write issue, -1 on read issue; level never exceeds DEPTH nor goes below 0.
REQ-020 SHALL advance the round-robin pointer only on an actual grant.
REQ-021 SHALL suppress a pop_valid whose read was issued before a flush was sampled.
REQ-022 SHALL treat fifo_full/fifo_empty as consistency inputs only; gating uses level.

Reset
REQ-023 SHALL, while rst_n=0, force immediately: state=HOLD, gnt=0, fifo_wr_en=0, fifo_rd_en=0, fifo_datain=0, pop_valid=0, pop_data=0, level=0, fifo_rst=1, busy=1, RR pointer=0, priority toggle=read-first.
REQ-024 SHALL, on reset asserted mid-transfer, drop all in-flight grants, writes and pop_valid without completion.

Verification
REQ-025 SHALL be verified by: reset release -> fifo_rst=1, busy=1 for 2 cycles, first gnt no earlier than cycle 3.
REQ-026 SHALL be verified by: req=4'b1111 held, pop_req=0 -> gnt sequence 0,1,2,3, level 1..4, then no gnt while level=4.
REQ-027 SHALL be verified by: only req[2] held continuously -> gnt[2] every other cycle until level=4.
REQ-028 SHALL be verified by: level=2, req[0]=1 and pop_req=1 held -> read issued first, then write, alternating; fifo_wr_en & fifo_rd_en never both 1; level stays 1..2.
REQ-029 SHALL be verified by: writes 0x11,0x22,0x33 then pop_req 3 cycles -> pop_valid with 0x11,0x22,0x33, each 2 cycles after its pop issue, level 0.
REQ-030 SHALL be verified by: level=3, read in flight, flush pulse -> FLUSH 1 cycle with fifo_rst=1, level=0, in-flight pop_valid suppressed, RUN resumes.
